// File: rtl/clusterv_sys_arbiter.sv
// Round-robin Wishbone arbiter sharing the cluster system bus between N initiators.
// Holds a grant for the whole initiator cycle and aborts accesses the target never answers.
module clusterv_sys_arbiter #(
  parameter int N_INITIATORS = 2,
  parameter int ADR_WIDTH    = 32,
  parameter int DAT_WIDTH    = 32,
  parameter int TIMEOUT      = 255,
  localparam int SEL_WIDTH   = DAT_WIDTH / 8,
  localparam int OWN_WIDTH   = (N_INITIATORS > 2) ? $clog2(N_INITIATORS) : 1
) (
  input  logic                              clock,
  input  logic                              reset_n,
  input  logic [N_INITIATORS*ADR_WIDTH-1:0] i_adr,
  input  logic [N_INITIATORS*DAT_WIDTH-1:0] i_dat_w,
  output logic [N_INITIATORS*DAT_WIDTH-1:0] i_dat_r,
  input  logic [N_INITIATORS-1:0]           i_cyc,
  input  logic [N_INITIATORS-1:0]           i_stb,
  input  logic [N_INITIATORS-1:0]           i_we,
  input  logic [N_INITIATORS*SEL_WIDTH-1:0] i_sel,
  output logic [N_INITIATORS-1:0]           i_ack,
  output logic [N_INITIATORS-1:0]           i_err,
  output logic [ADR_WIDTH-1:0]              t_adr,
  output logic [DAT_WIDTH-1:0]              t_dat_w,
  output logic [SEL_WIDTH-1:0]              t_sel,
  output logic                              t_cyc,
  output logic                              t_stb,
  output logic                              t_we,
  input  logic [DAT_WIDTH-1:0]              t_dat_r,
  input  logic                              t_ack,
  input  logic                              t_err,
  output logic [OWN_WIDTH-1:0]              owner,
  output logic                              busy,
  output logic                              timeout_evt
);

  localparam int CNT_WIDTH = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {StIdle, StGrant, StAbort, StDrain} state_e;

  state_e                r_state;
  logic [OWN_WIDTH-1:0]  r_owner;
  logic [OWN_WIDTH-1:0]  r_last;
  logic [CNT_WIDTH-1:0]  r_wcnt;

  logic [OWN_WIDTH-1:0]  w_winner;
  logic                  w_any_req;
  logic                  w_own_cyc;
  logic                  w_stall;
  logic                  w_expire;
  int                    w_own;

  assign w_own     = int'(r_owner);
  assign w_any_req = |i_cyc;
  assign w_own_cyc = i_cyc[w_own];

  // Scan from the highest offset down so the nearest requester after r_last wins.
  always_comb begin
    w_winner = r_owner;
    for (int k = N_INITIATORS; k >= 1; k--) begin
      if (i_cyc[(int'(r_last) + k) % N_INITIATORS]) begin
        w_winner = OWN_WIDTH'((int'(r_last) + k) % N_INITIATORS);
      end
    end
  end

  // A response on the expiry cycle clears the stall, so it always beats the abort.
  assign w_stall  = (TIMEOUT != 0) && (r_state == StGrant) && i_stb[w_own] && !t_ack && !t_err;
  assign w_expire = w_stall && (r_wcnt == CNT_WIDTH'(TIMEOUT - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= StIdle;
      r_owner <= '0;
      r_last  <= OWN_WIDTH'(N_INITIATORS - 1);
      r_wcnt  <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_any_req) begin
            r_owner <= w_winner;
            r_wcnt  <= '0;
            r_state <= StGrant;
          end
        end
        StGrant: begin
          if (!w_own_cyc) begin
            r_last  <= r_owner;
            r_wcnt  <= '0;
            r_state <= StIdle;
          end else if (w_expire) begin
            r_wcnt  <= '0;
            r_state <= StAbort;
          end else if (w_stall) begin
            r_wcnt  <= r_wcnt + 1'b1;
          end else begin
            r_wcnt  <= '0;
          end
        end
        StAbort: r_state <= StDrain;
        StDrain: begin
          if (!w_own_cyc) begin
            r_last  <= r_owner;
            r_state <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  always_comb begin
    t_adr   = '0;
    t_dat_w = '0;
    t_sel   = '0;
    t_cyc   = 1'b0;
    t_stb   = 1'b0;
    t_we    = 1'b0;
    i_ack   = '0;
    i_err   = '0;
    i_dat_r = '0;
    if (r_state == StGrant) begin
      t_adr   = i_adr[w_own*ADR_WIDTH +: ADR_WIDTH];
      t_dat_w = i_dat_w[w_own*DAT_WIDTH +: DAT_WIDTH];
      t_sel   = i_sel[w_own*SEL_WIDTH +: SEL_WIDTH];
      t_cyc   = i_cyc[w_own];
      t_stb   = i_stb[w_own];
      t_we    = i_we[w_own];
      i_ack[w_own] = t_ack & ~t_err;
      i_err[w_own] = t_err;
      i_dat_r[w_own*DAT_WIDTH +: DAT_WIDTH] = t_dat_r;
    end
    if (r_state == StAbort) begin
      i_err[w_own] = 1'b1;
    end
  end

  assign owner       = r_owner;
  assign busy        = (r_state != StIdle);
  assign timeout_evt = (r_state == StAbort);

endmodule

// File: tb/tb_clusterv_sys_arbiter.sv
// Bench for clusterv_sys_arbiter: directed corner cases plus random traffic checked
// every cycle against a grant/stall reference model.
module tb_clusterv_sys_arbiter;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 8;
  localparam int OW = 2;

  logic            clock;
  logic            reset_n;
  logic [N*AW-1:0] i_adr;
  logic [N*DW-1:0] i_dat_w;
  logic [N*DW-1:0] i_dat_r;
  logic [N-1:0]    i_cyc;
  logic [N-1:0]    i_stb;
  logic [N-1:0]    i_we;
  logic [N*SW-1:0] i_sel;
  logic [N-1:0]    i_ack;
  logic [N-1:0]    i_err;
  logic [AW-1:0]   t_adr;
  logic [DW-1:0]   t_dat_w;
  logic [SW-1:0]   t_sel;
  logic            t_cyc;
  logic            t_stb;
  logic            t_we;
  logic [DW-1:0]   t_dat_r;
  logic            t_ack;
  logic            t_err;
  logic [OW-1:0]   owner;
  logic            busy;
  logic            timeout_evt;

  clusterv_sys_arbiter #(
    .N_INITIATORS(N),
    .ADR_WIDTH   (AW),
    .DAT_WIDTH   (DW),
    .TIMEOUT     (TO)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .i_adr      (i_adr),
    .i_dat_w    (i_dat_w),
    .i_dat_r    (i_dat_r),
    .i_cyc      (i_cyc),
    .i_stb      (i_stb),
    .i_we       (i_we),
    .i_sel      (i_sel),
    .i_ack      (i_ack),
    .i_err      (i_err),
    .t_adr      (t_adr),
    .t_dat_w    (t_dat_w),
    .t_sel      (t_sel),
    .t_cyc      (t_cyc),
    .t_stb      (t_stb),
    .t_we       (t_we),
    .t_dat_r    (t_dat_r),
    .t_ack      (t_ack),
    .t_err      (t_err),
    .owner      (owner),
    .busy       (busy),
    .timeout_evt(timeout_evt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: who holds the bus, whether it is being aborted/drained, stall count.
  int m_owner;
  int m_last;
  int m_stall;
  bit m_grant;
  bit m_abort;
  bit m_drain;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = 0;
    m_last  = N - 1;
    m_stall = 0;
    m_grant = 0;
    m_abort = 0;
    m_drain = 0;
  endtask

  task automatic compare();
    logic [N-1:0]    e_ack;
    logic [N-1:0]    e_err;
    logic [N*DW-1:0] e_dr;
    logic [AW-1:0]   e_adr;
    logic [DW-1:0]   e_dw;
    logic [SW-1:0]   e_sel;
    logic            e_cyc, e_stb, e_we;
    int o;
    o = m_owner;
    e_ack = '0; e_err = '0; e_dr = '0; e_adr = '0; e_dw = '0; e_sel = '0;
    e_cyc = 1'b0; e_stb = 1'b0; e_we = 1'b0;
    if (m_grant) begin
      e_adr = i_adr[o*AW +: AW];
      e_dw  = i_dat_w[o*DW +: DW];
      e_sel = i_sel[o*SW +: SW];
      e_cyc = i_cyc[o];
      e_stb = i_stb[o];
      e_we  = i_we[o];
      e_ack[o] = t_ack & ~t_err;
      e_err[o] = t_err;
      e_dr[o*DW +: DW] = t_dat_r;
    end
    if (m_abort) e_err[o] = 1'b1;
    check("busy", busy, m_grant | m_abort | m_drain);
    check("owner", owner, o);
    check("timeout_evt", timeout_evt, m_abort);
    check("t_cyc", t_cyc, e_cyc);
    check("t_stb", t_stb, e_stb);
    check("t_we", t_we, e_we);
    check("t_adr", t_adr, e_adr);
    check("t_dat_w", t_dat_w, e_dw);
    check("t_sel", t_sel, e_sel);
    check("i_ack", i_ack, e_ack);
    check("i_err", i_err, e_err);
    check("i_dat_r", i_dat_r, e_dr);
  endtask

  task automatic advance();
    bit found;
    if (m_grant) begin
      if (!i_cyc[m_owner]) begin
        m_last  = m_owner;
        m_grant = 0;
      end else if (i_stb[m_owner] && !t_ack && !t_err) begin
        m_stall++;
        if (m_stall == TO) begin
          m_grant = 0;
          m_abort = 1;
          m_stall = 0;
        end
      end else begin
        m_stall = 0;
      end
    end else if (m_abort) begin
      m_abort = 0;
      m_drain = 1;
    end else if (m_drain) begin
      if (!i_cyc[m_owner]) begin
        m_last  = m_owner;
        m_drain = 0;
      end
    end else if (|i_cyc) begin
      found = 0;
      for (int k = 1; k <= N; k++) begin
        if (!found && i_cyc[(m_last + k) % N]) begin
          m_owner = (m_last + k) % N;
          found   = 1;
        end
      end
      m_grant = 1;
      m_stall = 0;
    end
  endtask

  // Called just after a negedge with inputs already set; returns at the next negedge.
  task automatic step();
    #1;
    compare();
    @(posedge clock);
    advance();
    @(negedge clock);
  endtask

  task automatic clear_inputs();
    i_adr = '0; i_dat_w = '0; i_cyc = '0; i_stb = '0; i_we = '0; i_sel = '0;
    t_dat_r = '0; t_ack = 1'b0; t_err = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic randomize_inputs(input bit dead);
    for (int k = 0; k < N; k++) begin
      if (!i_cyc[k]) i_cyc[k] = ($urandom_range(0, 3) == 0);
      else if ($urandom_range(0, 7) == 0) i_cyc[k] = 1'b0;
      i_stb[k] = ($urandom_range(0, 3) != 0);
      i_we[k]  = 1'($urandom);
      i_adr[k*AW +: AW]   = $urandom;
      i_dat_w[k*DW +: DW] = $urandom;
      i_sel[k*SW +: SW]   = SW'($urandom);
    end
    t_dat_r = $urandom;
    t_ack   = dead ? 1'b0 : ($urandom_range(0, 2) == 0);
    t_err   = dead ? 1'b0 : ($urandom_range(0, 9) == 0);
  endtask

  bit dead;

  initial begin
    reset_n = 1'b0;
    clear_inputs();
    model_reset();

    // Reset with every initiator requesting, then first grant goes to initiator 0.
    i_cyc = '1;
    i_stb = '1;
    @(negedge clock);
    @(negedge clock);
    #1;
    check("rst_t_cyc", t_cyc, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_owner", owner, 0);
    check("rst_i_ack", i_ack, 0);
    @(negedge clock);
    reset_n = 1'b1;
    step();
    #1;
    check("rel_t_cyc", t_cyc, 1'b1);
    check("rel_owner", owner, 0);
    t_ack = 1'b1;
    step();
    t_ack = 1'b0;
    i_cyc = 3'b000;
    repeat (3) step();

    // Watchdog: initiator 0 stalls until the access is aborted.
    clear_inputs();
    i_cyc = 3'b001;
    i_stb = 3'b001;
    do_reset();
    repeat (9) step();
    #1;
    check("to_evt", timeout_evt, 1'b1);
    check("to_err", i_err, 3'b001);
    check("to_t_cyc", t_cyc, 1'b0);
    step();
    #1;
    check("to_evt_once", timeout_evt, 1'b0);
    check("to_drain_busy", busy, 1'b1);
    step();
    i_cyc = 3'b000;
    step();
    #1;
    check("to_idle", busy, 1'b0);

    // Response on the expiry cycle beats the abort.
    clear_inputs();
    i_cyc = 3'b001;
    i_stb = 3'b001;
    do_reset();
    repeat (8) step();
    t_ack = 1'b1;
    #1;
    check("race_ack", i_ack, 3'b001);
    step();
    t_ack = 1'b0;
    #1;
    check("race_no_evt", timeout_evt, 1'b0);
    check("race_no_err", i_err, 3'b000);
    check("race_still_grant", t_cyc, 1'b1);
    i_cyc = 3'b000;
    repeat (2) step();

    // Reset in the middle of an initiator 1 read.
    clear_inputs();
    i_cyc = 3'b010;
    i_stb = 3'b010;
    do_reset();
    repeat (2) step();
    t_ack = 1'b1;
    reset_n = 1'b0;
    #1;
    check("mid_rst_t_cyc", t_cyc, 1'b0);
    check("mid_rst_ack", i_ack, 3'b000);
    check("mid_rst_err", i_err, 3'b000);
    check("mid_rst_busy", busy, 1'b0);
    model_reset();
    t_ack = 1'b0;
    i_cyc = 3'b011;
    @(negedge clock);
    reset_n = 1'b1;
    step();
    #1;
    check("mid_rst_tie_owner", owner, 0);
    check("mid_rst_tie_cyc", t_cyc, 1'b1);
    i_cyc = 3'b000;
    repeat (3) step();

    // Random traffic with periods of a dead target.
    dead = 0;
    for (int c = 0; c < 4000; c++) begin
      if (c % 64 == 0) dead = ($urandom_range(0, 2) == 0);
      randomize_inputs(dead);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
